// File: rtl/conv_ff_bank_if.sv
// conv_ff_bank_if: mode/enable/data inputs and q/q_bar/chg_cnt outputs of a conv_ff_bank.
// The err line exists only when SR_ILLEGAL_DETECT_EN is defined.
interface conv_ff_bank_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [1:0]       mode;
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic [CNT_W-1:0] chg_cnt;
`ifdef SR_ILLEGAL_DETECT_EN
  logic             err;
`endif

  modport master (
    output mode, en, a, b,
    input  q, q_bar, chg_cnt
`ifdef SR_ILLEGAL_DETECT_EN
    , input err
`endif
  );

  modport slave (
    input  mode, en, a, b,
    output q, q_bar, chg_cnt
`ifdef SR_ILLEGAL_DETECT_EN
    , output err
`endif
  );
endinterface

// File: rtl/conv_ff_bank.sv
// conv_ff_bank: WIDTH T flip-flops converted at run time to SR/JK/D/T, async cr/pr, saturating change counter.
// Latency: q updates on the sampling edge, q_bar combinational; no backpressure (en=0 holds). SR_ILLEGAL_DETECT_EN adds sticky err.
module conv_ff_bank #(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 8,
  parameter int RESET_Q = 0
) (
  input  logic             clk,
  input  logic             cr,
  input  logic             pr,
  conv_ff_bank_if.slave    bus
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  if (RESET_Q != 0) begin : g_reset_q_check
    $error("conv_ff_bank: RESET_Q must be 0");
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] t;
  logic [CNT_W-1:0] chg_cnt_q;
  logic [CNT_W-1:0] chg_cnt_d;
  logic             active;

  // The conversion logic only produces the toggle mask; the core is a plain T flop.
  always_comb begin
    active = bus.en & pr;
    t      = '0;
    if (active) begin
      case (bus.mode)
        MODE_SR: t = ((bus.a & ~q_q) | (bus.b & q_q)) & ~(bus.a & bus.b);
        MODE_JK: t = (bus.a & ~q_q) | (bus.b & q_q);
        MODE_D:  t = bus.a ^ q_q;
        MODE_T:  t = bus.a;
        default: t = '0;
      endcase
    end
  end

  always_comb begin
    q_d       = q_q ^ t;
    chg_cnt_d = chg_cnt_q;
    if ((|t) && (chg_cnt_q != {CNT_W{1'b1}})) begin
      chg_cnt_d = chg_cnt_q + CNT_W'(1);
    end
  end

  // Clear dominates preset; preset touches q only.
  always_ff @(posedge clk or negedge cr or negedge pr) begin
    if (!cr) begin
      q_q <= '0;
    end else if (!pr) begin
      q_q <= '1;
    end else begin
      q_q <= q_d;
    end
  end

  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      chg_cnt_q <= '0;
    end else begin
      chg_cnt_q <= chg_cnt_d;
    end
  end

`ifdef SR_ILLEGAL_DETECT_EN
  logic err_q;
  logic err_d;

  always_comb begin
    err_d = err_q;
    if (active && (bus.mode == MODE_SR) && (|(bus.a & bus.b))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`endif

  assign bus.q       = q_q;
  assign bus.q_bar   = ~q_q;
  assign bus.chg_cnt = chg_cnt_q;

endmodule

// File: tb/tb_conv_ff_bank.sv
// tb_conv_ff_bank: randomized and directed checks of conv_ff_bank against a characteristic-table model.
// Two instances share stimulus: CNT_W=8 and CNT_W=3 (saturation).
module tb_conv_ff_bank;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic cr  = 1'b0;
  logic pr  = 1'b1;

  logic [1:0]       mode_r = 2'b00;
  logic             en_r   = 1'b0;
  logic [WIDTH-1:0] a_r    = '0;
  logic [WIDTH-1:0] b_r    = '0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [WIDTH-1:0] m_q;
  int               m_cnt8;
  int               m_cnt3;
  logic             m_err;

  conv_ff_bank_if #(.WIDTH(WIDTH), .CNT_W(8)) ifm ();
  conv_ff_bank_if #(.WIDTH(WIDTH), .CNT_W(3)) ifs ();

  assign ifm.mode = mode_r;
  assign ifm.en   = en_r;
  assign ifm.a    = a_r;
  assign ifm.b    = b_r;
  assign ifs.mode = mode_r;
  assign ifs.en   = en_r;
  assign ifs.a    = a_r;
  assign ifs.b    = b_r;

  conv_ff_bank #(.WIDTH(WIDTH), .CNT_W(8), .RESET_Q(0)) dut (
    .clk (clk),
    .cr  (cr),
    .pr  (pr),
    .bus (ifm.slave)
  );

  conv_ff_bank #(.WIDTH(WIDTH), .CNT_W(3), .RESET_Q(0)) dut_sat (
    .clk (clk),
    .cr  (cr),
    .pr  (pr),
    .bus (ifs.slave)
  );

  always #5 clk = ~clk;

  function automatic logic next_bit(input logic [1:0] md, input logic s, input logic r, input logic qo);
    logic nb;
    case (md)
      2'b00: nb = (s && !r) ? 1'b1 : ((!s && r) ? 1'b0 : qo);
      2'b01: case ({s, r})
               2'b10:   nb = 1'b1;
               2'b01:   nb = 1'b0;
               2'b11:   nb = ~qo;
               default: nb = qo;
             endcase
      2'b10: nb = s;
      default: nb = qo ^ s;
    endcase
    return nb;
  endfunction

  task automatic model_edge();
    logic [WIDTH-1:0] nq;
    if (en_r) begin
      for (int i = 0; i < WIDTH; i++) nq[i] = next_bit(mode_r, a_r[i], b_r[i], m_q[i]);
      if (nq != m_q) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt3 < 7) m_cnt3++;
      end
      if (mode_r == 2'b00 && (a_r & b_r) != 0) m_err = 1'b1;
      m_q = nq;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic [1:0] md, input logic e, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    mode_r = md;
    en_r   = e;
    a_r    = av;
    b_r    = bv;
  endtask

  task automatic do_clear();
    @(negedge clk);
    cr = 1'b0;
    #1;
    cr = 1'b1;
    m_q = '0; m_cnt8 = 0; m_cnt3 = 0; m_err = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    cr = 1'b0; pr = 1'b1;
    #1;
    n_checks++;
    if (ifm.q !== 4'h0 || ifm.q_bar !== 4'hF || ifm.chg_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_clear: q=%h q_bar=%h cnt=%0d, want q=0 q_bar=F cnt=0", ifm.q, ifm.q_bar, ifm.chg_cnt);
    end
`ifdef SR_ILLEGAL_DETECT_EN
    n_checks++;
    if (ifm.err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_err: err=%b want 0", ifm.err);
    end
`endif
    cr = 1'b1;
    #1;
    pr = 1'b0;
    #1;
    n_checks++;
    if (ifm.q !== 4'hF || ifm.q_bar !== 4'h0 || ifm.chg_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL preset: q=%h q_bar=%h cnt=%0d, want q=F q_bar=0 cnt=0", ifm.q, ifm.q_bar, ifm.chg_cnt);
    end
    cr = 1'b0;
    #1;
    n_checks++;
    if (ifm.q !== 4'h0) begin
      n_errors++;
      $display("FAIL clear_over_preset: q=%h want 0", ifm.q);
    end
    pr = 1'b1;
    #1;
    cr = 1'b1;
    m_q = '0; m_cnt8 = 0; m_cnt3 = 0; m_err = 1'b0;
    step();
    n_checks++;
    if (ifm.q !== 4'h0 || ifm.chg_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL release_no_count: q=%h cnt=%0d want q=0 cnt=0", ifm.q, ifm.chg_cnt);
    end
  endtask

  task automatic test_sr();
    logic [WIDTH-1:0] exp_q [3];
    int               exp_c [3];
    logic [WIDTH-1:0] av [3];
    logic [WIDTH-1:0] bv [3];
    exp_q = '{4'b0101, 4'b0100, 4'b0100};
    exp_c = '{1, 2, 2};
    av    = '{4'b0101, 4'b0000, 4'b1111};
    bv    = '{4'b0000, 4'b0001, 4'b1111};
    for (int k = 0; k < 3; k++) begin
      set_in(2'b00, 1'b1, av[k], bv[k]);
      step();
      n_checks++;
      if (ifm.q !== exp_q[k] || ifm.q !== m_q || int'(ifm.chg_cnt) != exp_c[k]) begin
        n_errors++;
        $display("FAIL sr_step%0d: q=%b cnt=%0d want q=%b cnt=%0d", k, ifm.q, ifm.chg_cnt, exp_q[k], exp_c[k]);
      end
    end
`ifdef SR_ILLEGAL_DETECT_EN
    n_checks++;
    if (ifm.err !== 1'b1) begin
      n_errors++;
      $display("FAIL sr_err: err=%b want 1", ifm.err);
    end
`endif
  endtask

  task automatic test_jk_t();
    int c0;
    set_in(2'b01, 1'b1, 4'hF, 4'hF);
    step();
    n_checks++;
    if (ifm.q !== 4'b1011 || ifm.q !== m_q) begin
      n_errors++;
      $display("FAIL jk_toggle1: q=%b want 1011", ifm.q);
    end
    step();
    n_checks++;
    if (ifm.q !== 4'b0100 || ifm.q !== m_q) begin
      n_errors++;
      $display("FAIL jk_toggle2: q=%b want 0100", ifm.q);
    end
    c0 = int'(ifm.chg_cnt);
    set_in(2'b11, 1'b1, 4'b0011, 4'h0);
    for (int k = 0; k < 3; k++) step();
    n_checks++;
    if (ifm.q !== 4'b0111 || int'(ifm.chg_cnt) != c0 + 3 || int'(ifm.chg_cnt) != m_cnt8) begin
      n_errors++;
      $display("FAIL t_mode: q=%b cnt=%0d want q=0111 cnt=%0d", ifm.q, ifm.chg_cnt, c0 + 3);
    end
  endtask

  task automatic test_d_en();
    int c0;
    set_in(2'b10, 1'b1, 4'hA, 4'h3);
    step();
    n_checks++;
    if (ifm.q !== 4'hA || ifm.q_bar !== 4'h5) begin
      n_errors++;
      $display("FAIL d_mode: q=%h q_bar=%h want q=A q_bar=5", ifm.q, ifm.q_bar);
    end
    c0 = int'(ifm.chg_cnt);
    set_in(2'b10, 1'b0, 4'h5, 4'h0);
    for (int k = 0; k < 5; k++) step();
    n_checks++;
    if (ifm.q !== 4'hA || int'(ifm.chg_cnt) != c0) begin
      n_errors++;
      $display("FAIL en_hold: q=%h cnt=%0d want q=A cnt=%0d", ifm.q, ifm.chg_cnt, c0);
    end
  endtask

  task automatic test_saturation();
    do_clear();
    set_in(2'b11, 1'b1, 4'h1, 4'h0);
    for (int k = 0; k < 10; k++) step();
    n_checks++;
    if (ifs.chg_cnt !== 3'd7 || ifm.chg_cnt !== 8'd10) begin
      n_errors++;
      $display("FAIL saturate: cnt3=%0d cnt8=%0d want 7 and 10", ifs.chg_cnt, ifm.chg_cnt);
    end
  endtask

  task automatic test_mid_reset();
    set_in(2'b00, 1'b1, 4'hF, 4'hF);
    step();
    set_in(2'b11, 1'b1, 4'hF, 4'h0);
    step();
    step();
    @(negedge clk);
    cr = 1'b0;
    #1;
    n_checks++;
    if (ifm.q !== 4'h0 || ifm.chg_cnt !== 8'd0 || ifs.chg_cnt !== 3'd0) begin
      n_errors++;
      $display("FAIL mid_reset: q=%h cnt=%0d want 0 0", ifm.q, ifm.chg_cnt);
    end
`ifdef SR_ILLEGAL_DETECT_EN
    n_checks++;
    if (ifm.err !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset_err: err=%b want 0", ifm.err);
    end
`endif
    cr = 1'b1;
    m_q = '0; m_cnt8 = 0; m_cnt3 = 0; m_err = 1'b0;
    step();
    n_checks++;
    if (ifm.q !== 4'hF || ifm.chg_cnt !== 8'd1) begin
      n_errors++;
      $display("FAIL post_reset_edge: q=%h cnt=%0d want F 1", ifm.q, ifm.chg_cnt);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      set_in(2'($urandom_range(0, 3)), ($urandom_range(0, 4) != 0),
             WIDTH'($urandom), WIDTH'($urandom));
      step();
      n_checks++;
      if (ifm.q !== m_q || ifm.q_bar !== ~m_q || int'(ifm.chg_cnt) != m_cnt8 ||
          int'(ifs.chg_cnt) != m_cnt3 || ifs.q !== m_q) begin
        n_errors++;
        $display("FAIL random%0d: q=%h q_bar=%h cnt8=%0d cnt3=%0d want q=%h cnt8=%0d cnt3=%0d",
                 k, ifm.q, ifm.q_bar, ifm.chg_cnt, ifs.chg_cnt, m_q, m_cnt8, m_cnt3);
      end
`ifdef SR_ILLEGAL_DETECT_EN
      n_checks++;
      if (ifm.err !== m_err) begin
        n_errors++;
        $display("FAIL random_err%0d: err=%b want %b", k, ifm.err, m_err);
      end
`endif
    end
  endtask

  initial begin
    m_q = '0; m_cnt8 = 0; m_cnt3 = 0; m_err = 1'b0;
    test_reset();
    test_sr();
    test_jk_t();
    test_d_en();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
